// File: rtl/temp_report_pkg.sv
// Shared constants and helpers for the temperature report framer:
// FSM encoding, frame byte indices and byte-construction functions.
package temp_report_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [2:0] BYTE_HDR  = 3'd0;
  localparam logic [2:0] BYTE_CH   = 3'd1;
  localparam logic [2:0] BYTE_MSB  = 3'd2;
  localparam logic [2:0] BYTE_LSB  = 3'd3;
  localparam logic [2:0] BYTE_CSUM = 3'd4;

  localparam int         FRAME_LEN    = 5;
  localparam logic [2:0] LAST_BYTE    = 3'(FRAME_LEN - 1);
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // Upper temperature bits [temp_w-1:8], sign-extended to a full byte.
  function automatic logic [7:0] sign_ext_msb(input logic [15:0] temp, input int temp_w);
    logic [7:0] msb;
    for (int i = 0; i < 8; i++) begin
      if (i < temp_w - 8) begin
        msb[i] = temp[8 + i];
      end else begin
        msb[i] = temp[temp_w - 1];
      end
    end
    return msb;
  endfunction

  function automatic logic [7:0] frame_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                                input logic [7:0] b3);
    return b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after an internal
// pointer (cyclic); the pointer moves past the winner when the grant is taken.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  logic [IDX_W-1:0] ptr_r;

  // Lowest requester overall, then overridden by the lowest at or after ptr_r.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      gnt_valid = req[c] ? 1'b1 : gnt_valid;
      gnt_idx   = req[c] ? IDX_W'(c) : gnt_idx;
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      gnt_idx = (req[c] && (IDX_W'(c) >= ptr_r)) ? IDX_W'(c) : gnt_idx;
    end
    gnt = gnt_valid ? (NUM_CH'(1'b1) << gnt_idx) : '0;
  end

  // Pointer advances to the channel after the one just served.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (advance && gnt_valid) begin
      ptr_r <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/temp_uart_reporter.sv
// Latches per-channel temperature samples and sends each as a 5-byte
// checksummed frame over a start/done UART handshake, round-robin by channel.
module temp_uart_reporter
  import temp_report_pkg::*;
#(
  parameter int         NUM_CH     = 2,
  parameter int         TEMP_W     = 13,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF,
  parameter int         PERIODIC   = 0,
  parameter int         PERIOD_CYC = 100_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*TEMP_W-1:0] temp_i,
  input  logic [NUM_CH-1:0]        valid_i,
  output logic                     tx_start_o,
  output logic [7:0]               tx_byte_o,
  input  logic                     tx_done_i,
  output logic                     busy_o,
  output logic [NUM_CH-1:0]        overrun_o,
  output logic [NUM_CH*TEMP_W-1:0] last_temp_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(PERIOD_CYC);

  logic [1:0]               state_r;
  logic [NUM_CH-1:0]        pending_r;
  logic [NUM_CH-1:0]        overrun_r;
  logic [NUM_CH*TEMP_W-1:0] last_temp_r;
  logic [TEMP_W-1:0]        snap_temp_r;
  logic [2:0]               snap_ch_r;
  logic [2:0]               byte_idx_r;
  logic                     tx_start_r;
  logic [7:0]               tx_byte_r;
  logic                     busy_r;
  logic [CNT_W-1:0]         period_cnt_r;

  logic [NUM_CH-1:0] gnt_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic              gnt_valid_s;
  logic              take_s;
  logic              wrap_s;
  logic [NUM_CH-1:0] pending_nxt_s;
  logic [TEMP_W-1:0] sel_temp_s;
  logic [2:0]        byte_sel_s;
  logic [15:0]       temp16_s;
  logic [7:0]        ch_byte_s;
  logic [7:0]        msb_byte_s;
  logic [7:0]        lsb_byte_s;
  logic [7:0]        frame_byte_s;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       (pending_r),
    .advance   (take_s),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  assign take_s = (state_r == ST_IDLE) && gnt_valid_s;
  assign wrap_s = (PERIODIC != 0) && (period_cnt_r == CNT_W'(PERIOD_CYC - 1));
  // A new sample on the channel being taken keeps its pending bit set.
  assign pending_nxt_s = (pending_r & ~(gnt_s & {NUM_CH{take_s}})) | valid_i | {NUM_CH{wrap_s}};

  // One-hot mux of the granted channel's stored value.
  always_comb begin
    sel_temp_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_temp_s = sel_temp_s | (last_temp_r[k*TEMP_W +: TEMP_W] & {TEMP_W{gnt_s[k]}});
    end
  end

  assign temp16_s   = 16'(snap_temp_r);
  assign ch_byte_s  = {5'b00000, snap_ch_r};
  assign msb_byte_s = sign_ext_msb(temp16_s, TEMP_W);
  assign lsb_byte_s = snap_temp_r[7:0];

  // GAP loads the following byte, every other state the current one.
  always_comb begin
    if (state_r == ST_GAP) begin
      byte_sel_s = byte_idx_r + 3'd1;
    end else begin
      byte_sel_s = byte_idx_r;
    end
    case (byte_sel_s)
      BYTE_HDR:  frame_byte_s = HDR_BYTE;
      BYTE_CH:   frame_byte_s = ch_byte_s;
      BYTE_MSB:  frame_byte_s = msb_byte_s;
      BYTE_LSB:  frame_byte_s = lsb_byte_s;
      BYTE_CSUM: frame_byte_s = frame_checksum(ch_byte_s, msb_byte_s, lsb_byte_s);
      default:   frame_byte_s = 8'h00;
    endcase
  end

  // Sample capture, pending/overrun bookkeeping and the periodic timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r    <= '0;
      overrun_r    <= '0;
      last_temp_r  <= '0;
      period_cnt_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
      overrun_r <= overrun_r | (valid_i & pending_r);
      for (int k = 0; k < NUM_CH; k++) begin
        if (valid_i[k]) begin
          last_temp_r[k*TEMP_W +: TEMP_W] <= temp_i[k*TEMP_W +: TEMP_W];
        end else begin
          last_temp_r[k*TEMP_W +: TEMP_W] <= last_temp_r[k*TEMP_W +: TEMP_W];
        end
      end
      if (wrap_s || (PERIODIC == 0)) begin
        period_cnt_r <= '0;
      end else begin
        period_cnt_r <= period_cnt_r + CNT_W'(1);
      end
    end
  end

  // Frame FSM: snapshot in LOAD, then SEND/GAP per byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      snap_temp_r <= '0;
      snap_ch_r   <= 3'd0;
      byte_idx_r  <= 3'd0;
      tx_start_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            state_r     <= ST_LOAD;
            snap_temp_r <= sel_temp_s;
            snap_ch_r   <= 3'(gnt_idx_s);
            byte_idx_r  <= BYTE_HDR;
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r    <= ST_SEND;
          tx_start_r <= 1'b1;
          tx_byte_r  <= frame_byte_s;
        end
        ST_SEND: begin
          if (tx_done_i) begin
            state_r    <= ST_GAP;
            tx_start_r <= 1'b0;
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_GAP: begin
          if (byte_idx_r == LAST_BYTE) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r    <= ST_SEND;
            byte_idx_r <= byte_idx_r + 3'd1;
            tx_start_r <= 1'b1;
            tx_byte_r  <= frame_byte_s;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tx_start_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start_o  = tx_start_r;
  assign tx_byte_o   = tx_byte_r;
  assign busy_o      = busy_r;
  assign overrun_o   = overrun_r;
  assign last_temp_o = last_temp_r;

endmodule

// File: tb/tb_temp_uart_reporter.sv
// Directed bench for temp_uart_reporter: one event-driven instance and one
// periodic instance, each served by a simple UART done-pulse responder.
module tb_temp_uart_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event-driven instance
  logic        rst, tx_start, tx_done, busy;
  logic [25:0] temp, last_temp;
  logic [1:0]  valid, overrun;
  logic [7:0]  tx_byte;

  // Periodic instance
  logic        p_rst, p_tx_start, p_tx_done, p_busy;
  logic [25:0] p_temp, p_last_temp;
  logic [1:0]  p_valid, p_overrun;
  logic [7:0]  p_tx_byte;

  temp_uart_reporter dut (
    .clk_i(clk), .rst_i(rst), .temp_i(temp), .valid_i(valid),
    .tx_start_o(tx_start), .tx_byte_o(tx_byte), .tx_done_i(tx_done),
    .busy_o(busy), .overrun_o(overrun), .last_temp_o(last_temp)
  );

  temp_uart_reporter #(.PERIODIC(1), .PERIOD_CYC(1000)) dut_p (
    .clk_i(clk), .rst_i(p_rst), .temp_i(p_temp), .valid_i(p_valid),
    .tx_start_o(p_tx_start), .tx_byte_o(p_tx_byte), .tx_done_i(p_tx_done),
    .busy_o(p_busy), .overrun_o(p_overrun), .last_temp_o(p_last_temp)
  );

  logic [7:0] byte_q[$];
  logic [7:0] p_q[$];
  int         p_t[$];
  int         hold_err = 0;
  int         gap_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model for the event-driven instance: done 4 cycles into each byte.
  initial begin : resp_main
    int wcnt;
    logic [7:0] held;
    wcnt = 0;
    held = 8'h00;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_done) begin
        tx_done = 1'b0;
        wcnt = 0;
        if (tx_start) gap_err++;
      end else if (tx_start) begin
        if (wcnt == 0) held = tx_byte;
        else if (tx_byte !== held) hold_err++;
        if (wcnt == 3) begin
          tx_done = 1'b1;
          byte_q.push_back(tx_byte);
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // UART model for the periodic instance, also recording byte times.
  initial begin : resp_periodic
    int wcnt;
    wcnt = 0;
    p_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (p_tx_done) begin
        p_tx_done = 1'b0;
        wcnt = 0;
      end else if (p_tx_start) begin
        if (wcnt == 2) begin
          p_tx_done = 1'b1;
          p_q.push_back(p_tx_byte);
          p_t.push_back(cyc);
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int i = 0; i < 2000 && byte_q.size() < n; i++) tick();
    check_eq(tag, byte_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input bit periodic, input logic [39:0] exp);
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = 8'hxx;
      if (periodic && p_q.size() > 0) b = p_q.pop_front();
      else if (!periodic && byte_q.size() > 0) b = byte_q.pop_front();
      check_eq($sformatf("%s_b%0d", tag, i), {24'd0, b}, {24'd0, exp[39-8*i -: 8]});
    end
  endtask

  initial begin
    rst = 1'b1; valid = 2'b00; temp = '0;
    p_rst = 1'b1; p_valid = 2'b00; p_temp = '0;
    repeat (3) tick();
    check_eq("rst_start", {31'd0, tx_start}, 32'd0);
    check_eq("rst_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ovr", {30'd0, overrun}, 32'd0);
    check_eq("rst_last", {6'd0, last_temp}, 32'd0);
    rst = 1'b0;
    tick();

    // Positive value on ch0, latency capture -> LOAD -> SEND
    temp[12:0] = 13'h0190; valid = 2'b01;
    tick(); valid = 2'b00;
    check_eq("cap_last0", {19'd0, last_temp[12:0]}, 32'h0190);
    check_eq("cap_start", {31'd0, tx_start}, 32'd0);
    tick();
    check_eq("load_busy", {31'd0, busy}, 32'd1);
    check_eq("load_start", {31'd0, tx_start}, 32'd0);
    tick();
    check_eq("send_start", {31'd0, tx_start}, 32'd1);
    check_eq("send_b0", {24'd0, tx_byte}, 32'h00A5);
    wait_bytes("pos_len", 5);
    check_frame("pos", 1'b0, 40'hA5_00_01_90_91);
    wait_idle("pos_idle");

    // Negative value on ch1
    temp[25:13] = 13'h1E70; valid = 2'b10;
    tick(); valid = 2'b00;
    wait_bytes("neg_len", 5);
    check_frame("neg", 1'b0, 40'hA5_01_FE_70_8F);
    wait_idle("neg_idle");

    // Simultaneous events: ch0 first both times
    for (int r = 0; r < 2; r++) begin
      temp = {13'h0FFF, 13'h0005}; valid = 2'b11;
      tick(); valid = 2'b00;
      wait_bytes($sformatf("sim%0d_len", r), 10);
      check_frame($sformatf("sim%0d_ch0", r), 1'b0, 40'hA5_00_00_05_05);
      check_frame($sformatf("sim%0d_ch1", r), 1'b0, 40'hA5_01_0F_FF_F1);
      wait_idle($sformatf("sim%0d_idle", r));
    end

    // Overrun on ch1 while a ch0 frame is in flight
    temp[12:0] = 13'h0190; valid = 2'b01;
    tick(); valid = 2'b00;
    repeat (4) tick();
    check_eq("ovr_inflight", {31'd0, tx_start}, 32'd1);
    temp[25:13] = 13'h0100; valid = 2'b10;
    tick(); valid = 2'b00;
    check_eq("ovr_first", {30'd0, overrun}, 32'd0);
    repeat (2) tick();
    temp[25:13] = 13'h0200; valid = 2'b10;
    tick(); valid = 2'b00;
    check_eq("ovr_set", {30'd0, overrun}, 32'd2);
    check_eq("ovr_last1", {19'd0, last_temp[25:13]}, 32'h0200);
    wait_bytes("ovr_len", 10);
    check_frame("ovr_ch0", 1'b0, 40'hA5_00_01_90_91);
    check_frame("ovr_ch1", 1'b0, 40'hA5_01_02_00_03);
    wait_idle("ovr_idle");
    check_eq("ovr_sticky", {30'd0, overrun}, 32'd2);

    // Reset while B2 is being sent
    temp[12:0] = 13'h0190; valid = 2'b01;
    tick(); valid = 2'b00;
    for (int i = 0; i < 500 && !(byte_q.size() == 2 && tx_start); i++) tick();
    check_eq("mid_reach", byte_q.size(), 2);
    check_eq("mid_b2", {24'd0, tx_byte}, 32'h0001);
    rst = 1'b1;
    tick();
    check_eq("mid_start", {31'd0, tx_start}, 32'd0);
    check_eq("mid_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_ovr", {30'd0, overrun}, 32'd0);
    check_eq("mid_last", {6'd0, last_temp}, 32'd0);
    rst = 1'b0;
    repeat (40) tick();
    check_eq("mid_nomore", byte_q.size(), 2);
    check_eq("mid_quiet", {31'd0, tx_start}, 32'd0);
    byte_q.delete();

    // Periodic instance: initial samples, then re-reports every 1000 cycles
    p_rst = 1'b0;
    p_temp = {13'h1E70, 13'h0190}; p_valid = 2'b11;
    tick(); p_valid = 2'b00;
    repeat (2500) tick();
    check_eq("per_len", p_q.size(), 30);
    if (p_t.size() >= 21) check_eq("per_interval", p_t[20] - p_t[10], 1000);
    for (int f = 0; f < 3; f++) begin
      check_frame($sformatf("per%0d_ch0", f), 1'b1, 40'hA5_00_01_90_91);
      check_frame($sformatf("per%0d_ch1", f), 1'b1, 40'hA5_01_FE_70_8F);
    end
    check_eq("per_ovr", {30'd0, p_overrun}, 32'd0);
    check_eq("per_last", {6'd0, p_last_temp}, {6'd0, 13'h1E70, 13'h0190});

    check_eq("hold_stable", hold_err, 0);
    check_eq("gap_low", gap_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
